// File: rtl/bus_cpu_core_if.sv
// Instruction handshake bundle for bus_cpu_core.
// Master offers instructions; slave (core) accepts and pulses done.
interface bus_cpu_core_if #(
  parameter int WIDTH = 8,
  parameter int RW    = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [4+3*RW-1:0] instr;
  logic [WIDTH-1:0]  instr_imm;
  logic              done;

  modport master (
    output instr_valid, instr, instr_imm,
    input  instr_ready, done
  );

  modport slave (
    input  instr_valid, instr, instr_imm,
    output instr_ready, done
  );
endinterface

// File: rtl/bus_cpu_core.sv
// Single-bus CPU datapath with a multi-cycle controller.
// Registers, A/B latches and ALU share one muxed internal bus.
module bus_cpu_core #(
  parameter int              WIDTH     = 8,
  parameter int              NREGS     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             RW        = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  bus_cpu_core_if.slave    cpu_if,
  output logic             flag_z,
  output logic             flag_c,
  output logic [WIDTH-1:0] bus,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int IW = 4 + 3*RW;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_LDI = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE, S_LDA, S_LDB, S_EXEC
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ir_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic             z_q, c_q;
  logic             done_q, done_d;

  logic [3:0]       op, in_op;
  logic [RW-1:0]    dst, sa, sb;
  logic             accept, in_alu, in_ldi, op_alu;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   sum;

  assign op  = ir_q[IW-1 -: 4];
  assign dst = ir_q[3*RW-1 -: RW];
  assign sa  = ir_q[2*RW-1 -: RW];
  assign sb  = ir_q[RW-1:0];

  assign in_op  = cpu_if.instr[IW-1 -: 4];
  assign in_alu = (in_op != 4'd0) && (in_op <= OP_MOV);
  assign in_ldi = (in_op == OP_LDI);
  assign op_alu = (op != 4'd0) && (op <= OP_MOV);
  assign accept = (state_q == S_IDLE) && cpu_if.instr_valid;

  assign cpu_if.done = done_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;
  assign dbg_data    = regs_q[dbg_sel];

  // Controller state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sequencing: ALU ops load both operands, LDI goes straight to writeback
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && in_alu)      state_d = S_LDA;
        else if (accept && in_ldi) state_d = S_EXEC;
        else if (accept)           done_d  = 1'b1;
      end
      S_LDA:  state_d = S_LDB;
      S_LDB:  state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state outputs: handshake ready and bus source select
  always_comb begin
    cpu_if.instr_ready = 1'b0;
    bus                = '0;
    unique case (state_q)
      S_IDLE: cpu_if.instr_ready = 1'b1;
      S_LDA:  bus = regs_q[sa];
      S_LDB:  bus = regs_q[sb];
      S_EXEC: bus = (op == OP_LDI) ? imm_q : alu_res;
      default: bus = '0;
    endcase
  end

  // ALU on latched operands; carry carries borrow/shift-out too
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = '0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB: begin
        sum     = {1'b0, a_q} - {1'b0, b_q};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        alu_c   = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      OP_MOV: alu_res = a_q;
      default: alu_res = '0;
    endcase
  end

  // Datapath: instruction latch, operand latches, writeback, flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q   <= '0;
      imm_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      done_q <= done_d;
      if (accept) begin
        ir_q  <= cpu_if.instr;
        imm_q <= cpu_if.instr_imm;
      end
      if (state_q == S_LDA) a_q <= bus;
      if (state_q == S_LDB) b_q <= bus;
      if (state_q == S_EXEC) begin
        regs_q[dst] <= bus;
        if (op_alu) begin
          z_q <= (bus == '0);
          c_q <= alu_c;
        end
      end
    end
  end

endmodule
